// File: rtl/imem_loader.sv
// Purpose: packs a valid/ready byte stream little-endian into words and writes them sequentially into IMEM from address 0.
// Latency: the handshake of the last byte of a word at edge N gives mem_we=1 in the cycle after N (4 bytes per 5 cycles max).
// Backpressure: byte_ready is low outside RECV and during the write cycle; a held byte waits there until it is accepted.
module imem_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W = ADDR_WIDTH + 1;

  // Index of the byte that completes a word.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  // word_count value seen during the final write of a session.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0]   part_q, part_d;
  logic                    byte_ready_q, byte_ready_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [CNT_W-1:0]        word_count_q, word_count_d;
  logic [DATA_WIDTH-1:0]   checksum_q, checksum_d;

  logic                    byte_fire;

  // A byte transfers only when the registered ready and the source's valid coincide.
  assign byte_fire = byte_valid && byte_ready_q;

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    part_d       = part_q;
    byte_ready_d = byte_ready_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    busy_d       = busy_q;
    done_d       = done_q;
    word_count_d = word_count_q;
    checksum_d   = checksum_q;

    unique case (state_q)
      // Idle and done both accept start and open a fresh session at address 0.
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RECV;
          byte_ready_d = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          word_count_d = '0;
          checksum_d   = '0;
          mem_addr_d   = '0;
          byte_idx_d   = '0;
          part_d       = '0;
        end
      end

      // Collect bytes into their little-endian lane; the last lane launches the write.
      S_RECV: begin
        if (byte_fire) begin
          for (int k = 0; k < BYTES; k++) begin
            if (byte_idx_q == IDX_W'(k)) begin
              part_d[8*k +: 8] = byte_data;
            end
          end
          if (byte_idx_q == LAST_IDX) begin
            state_d      = S_WRITE;
            byte_ready_d = 1'b0;
            mem_we_d     = 1'b1;
            mem_wdata_d  = part_d;
            byte_idx_d   = '0;
            part_d       = '0;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end

      // Single write cycle: fold the word into the session totals, then advance or finish.
      S_WRITE: begin
        checksum_d   = checksum_q ^ mem_wdata_q;
        word_count_d = word_count_q + 1'b1;
        if (word_count_q == LAST_CNT) begin
          // Address stays on the last written word; no increment past the end.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d      = S_RECV;
          mem_addr_d   = mem_addr_q + 1'b1;
          byte_ready_d = 1'b1;
        end
      end
    endcase
  end

  // State and all outputs are registered; reset aborts any session and drops the partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= '0;
      part_q       <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      word_count_q <= '0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      part_q       <= part_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      word_count_q <= word_count_d;
      checksum_q   <= checksum_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = word_count_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: three instances (16, 32 and 1 words per session) share the byte bus;
// a transaction-level model predicts every output each cycle, and directed tests pin literal results.
module tb_imem_loader;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic [2:0] start_v;

  logic        rdy_w   [ND];
  logic        we_w    [ND];
  logic [4:0]  addr_w  [ND];
  logic [31:0] wdata_w [ND];
  logic        busy_w  [ND];
  logic        done_w  [ND];
  logic [5:0]  wc_w    [ND];
  logic [31:0] cks_w   [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    imem_loader #(
      .ADDR_WIDTH(5),
      .DATA_WIDTH(32),
      .NUM_WORDS((g == 0) ? 16 : ((g == 1) ? 32 : 1))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_v[g]),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .byte_ready(rdy_w[g]),
      .mem_we    (we_w[g]),
      .mem_addr  (addr_w[g]),
      .mem_wdata (wdata_w[g]),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .word_count(wc_w[g]),
      .checksum  (cks_w[g])
    );
  end

  int checks = 0;
  int errors = 0;

  function automatic int nw(input int d);
    return (d == 0) ? 16 : ((d == 1) ? 32 : 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (session / byte-count level) ----------------
  bit          m_sess  [ND];
  bit          m_wrp   [ND];
  bit          m_rstf  [ND];
  int          m_nb    [ND];
  int          m_words [ND];
  logic [31:0] m_part  [ND];
  logic [31:0] m_word  [ND];
  logic [31:0] m_cks   [ND];

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        m_sess[d] = 0; m_wrp[d] = 0; m_rstf[d] = 1; m_nb[d] = 0;
        m_words[d] = 0; m_part[d] = 0; m_word[d] = 0; m_cks[d] = 0;
      end else begin
        m_rstf[d] = 0;
        if (m_wrp[d]) begin
          m_wrp[d] = 0;
          m_cks[d] = m_cks[d] ^ m_word[d];
          m_words[d]++;
        end else if (m_sess[d] && m_words[d] < nw(d)) begin
          if (byte_valid) begin
            m_part[d] = m_part[d] | (32'(byte_data) << (8 * m_nb[d]));
            m_nb[d]++;
            if (m_nb[d] == 4) begin
              m_wrp[d]  = 1;
              m_word[d] = m_part[d];
              m_part[d] = 0;
              m_nb[d]   = 0;
            end
          end
        end else if (start_v[d]) begin
          m_sess[d] = 1; m_words[d] = 0; m_cks[d] = 0; m_nb[d] = 0; m_part[d] = 0;
        end
      end
    end
  end

  // ---------------- write capture (ROM-style image per instance) ----------------
  logic [31:0] img [ND][32];
  int wr_cnt [ND];
  int last_addr [ND];
  int we_cyc [ND];
  int done_cyc [ND];
  int cyc = 0;

  // Single compare process: every output of every instance, every cycle.
  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("byte_ready[%0d]", d), rdy_w[d], m_sess[d] && !m_wrp[d] && m_words[d] < nw(d));
      check($sformatf("mem_we[%0d]", d), we_w[d], m_wrp[d]);
      check($sformatf("mem_addr[%0d]", d), addr_w[d], (m_words[d] < nw(d)) ? m_words[d] : nw(d) - 1);
      check($sformatf("busy[%0d]", d), busy_w[d], m_sess[d] && m_words[d] < nw(d));
      check($sformatf("done[%0d]", d), done_w[d], m_sess[d] && m_words[d] == nw(d));
      check($sformatf("word_count[%0d]", d), wc_w[d], m_words[d]);
      check($sformatf("checksum[%0d]", d), cks_w[d], m_cks[d]);
      if (m_wrp[d]) check($sformatf("mem_wdata[%0d]", d), wdata_w[d], m_word[d]);
      if (m_rstf[d]) check($sformatf("rst_wdata[%0d]", d), wdata_w[d], 0);
      if (we_w[d] === 1'b1) begin
        img[d][addr_w[d]] = wdata_w[d];
        wr_cnt[d]++;
        last_addr[d] = addr_w[d];
        we_cyc[d] = cyc;
      end
      if (done_w[d] === 1'b1 && done_cyc[d] < 0) done_cyc[d] = cyc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int d);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
  endtask

  task automatic clear_img(input int d);
    for (int a = 0; a < 32; a++) img[d][a] = 32'h0;
    wr_cnt[d] = 0; last_addr[d] = -1; we_cyc[d] = -1; done_cyc[d] = -1;
  endtask

  // Present one byte after 'gap' idle cycles and hold it until the instance accepts it.
  task automatic send(input int d, input logic [7:0] b, input int gap);
    int w;
    w = 0;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (rdy_w[d] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout: dut %0d never took byte 0x%0h", d, b);
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input int d);
    int w;
    w = 0;
    while (done_w[d] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      checks++; errors++;
      $display("FAIL done_timeout: dut %0d never reached done", d);
    end
  endtask

  logic [31:0] ew;
  logic [31:0] ecks;
  logic [7:0]  pat [4];
  int          gp  [4];

  initial begin
    rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; start_v = 3'b000;
    for (int d = 0; d < ND; d++) clear_img(d);
    tick(3);
    check("reset_ready", rdy_w[0], 0);
    check("reset_addr", addr_w[0], 0);
    check("reset_wdata", wdata_w[0], 0);
    check("reset_count", wc_w[0], 0);
    rst = 1'b0;
    tick(2);

    // Basic load: bytes 0x00..0x3F, valid held high.
    clear_img(0);
    pulse_start(0);
    for (int i = 0; i < 64; i++) send(0, 8'(i), 0);
    byte_valid = 1'b0;
    wait_done(0);
    tick(1);
    check("basic_writes", wr_cnt[0], 16);
    check("basic_word0", img[0][0], 32'h03020100);
    check("basic_word15", img[0][15], 32'h3F3E3D3C);
    check("basic_last_addr", last_addr[0], 15);
    check("basic_count", wc_w[0], 16);
    check("basic_checksum", cks_w[0], 32'h0);
    check("basic_done", done_w[0], 1);
    for (int i = 0; i < 16; i++) begin
      ew = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      check($sformatf("basic_readback[%0d]", i), img[0][i], ew);
    end

    // Restart from done, then a gappy stream.
    clear_img(0);
    pulse_start(0);
    check("restart_done_low", done_w[0], 0);
    check("restart_count", wc_w[0], 0);
    check("restart_checksum", cks_w[0], 0);
    pat = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    gp  = '{2, 0, 3, 1};
    for (int i = 0; i < 4; i++) send(0, pat[i], gp[i]);
    byte_valid = 1'b0;
    check("bp_ready_in_write", rdy_w[0], 0);
    check("bp_we_in_write", we_w[0], 1);
    check("bp_wdata", wdata_w[0], 32'hEFBEADDE);
    check("bp_addr", addr_w[0], 0);
    tick(1);
    // start inside a session has no effect.
    pulse_start(0);
    check("recv_start_ignored", wc_w[0], 1);
    check("recv_start_busy", busy_w[0], 1);
    send(0, 8'h11, 1);
    send(0, 8'h22, 0);
    byte_valid = 1'b0;
    // Abort with one word plus two bytes collected.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy_w[0], 0);
    check("abort_count", wc_w[0], 0);
    check("abort_checksum", cks_w[0], 0);
    check("abort_wdata", wdata_w[0], 0);
    tick(2);
    clear_img(0);
    pulse_start(0);
    for (int i = 0; i < 64; i++) send(0, 8'(8'h80 + i), i % 3);
    byte_valid = 1'b0;
    wait_done(0);
    tick(1);
    check("fresh_word0", img[0][0], 32'h83828180);
    check("fresh_writes", wr_cnt[0], 16);
    check("fresh_word15", img[0][15], 32'hBFBEBDBC);

    // 32-word session: full address range, no wrap, no extra write.
    clear_img(1);
    pulse_start(1);
    for (int i = 0; i < 128; i++) send(1, 8'(i * 3), 0);
    byte_valid = 1'b0;
    wait_done(1);
    tick(1);
    ecks = 32'h0;
    for (int i = 0; i < 32; i++)
      ecks = ecks ^ {8'((4*i+3)*3), 8'((4*i+2)*3), 8'((4*i+1)*3), 8'((4*i)*3)};
    check("n32_writes", wr_cnt[1], 32);
    check("n32_last_addr", last_addr[1], 31);
    check("n32_word31", img[1][31], 32'h7D7A7774);
    check("n32_count", wc_w[1], 32);
    check("n32_checksum", cks_w[1], ecks);
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      check("n32_done_ready", rdy_w[1], 0);
      tick(1);
    end
    byte_valid = 1'b0;
    check("n32_no_extra_write", wr_cnt[1], 32);

    // Single-word session.
    clear_img(2);
    pulse_start(2);
    pat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) send(2, pat[i], 0);
    byte_valid = 1'b0;
    wait_done(2);
    tick(2);
    check("n1_writes", wr_cnt[2], 1);
    check("n1_word", img[2][0], 32'hD4C3B2A1);
    check("n1_addr", last_addr[2], 0);
    check("n1_done_latency", done_cyc[2] - we_cyc[2], 1);
    check("n1_checksum", cks_w[2], 32'hD4C3B2A1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
